// File: rtl/sad_datapath.sv
// sad_datapath: index/accumulator datapath of the SAD engine.
// Walks an element index over two pixel blocks, accumulates |A-B|,
// flags block completion and registers the final sum on request.
// Optional build macro: SAD_SAT_EN (saturating accumulator + sticky overflow flag).
module sad_datapath #(
    parameter int PIX_W  = 8,
    parameter int N      = 256,
    parameter int ADDR_W = 8,
    parameter int SUM_W  = 16
) (
    input  logic              clk,
    input  logic              Mrst,
    input  logic              rst,
    input  logic              en,
    input  logic              en_reg,
    input  logic [PIX_W-1:0]  a_pix,
    input  logic [PIX_W-1:0]  b_pix,
    output logic [ADDR_W-1:0] addr,
    output logic              comp,
    output logic [SUM_W-1:0]  sad,
    output logic              sad_valid,
    output logic              sad_ovf
);

    // idx is one bit wider than addr so it can hold the terminal value N
    localparam logic [ADDR_W:0] IDX_END = (ADDR_W+1)'(N);

    logic [ADDR_W:0]  idx;
    logic [SUM_W-1:0] acc;
    logic [SUM_W-1:0] acc_next;
    logic [PIX_W:0]   diff;
    logic [PIX_W:0]   mag;
    logic [SUM_W-1:0] term;

    assign addr = idx[ADDR_W-1:0];
    assign comp = (idx == IDX_END);

    // absolute difference on a PIX_W+1-bit signed difference, zero-extended
    always_comb begin
        diff = {1'b0, a_pix} - {1'b0, b_pix};
        mag  = diff[PIX_W] ? (~diff + (PIX_W+1)'(1)) : diff;
        term = SUM_W'(mag);
    end

`ifdef SAD_SAT_EN
    logic [SUM_W:0] sum_ext;
    logic           ovf_hit;
    logic           ovf_q;

    // widened add so the carry-out tells us when to clamp
    always_comb begin
        sum_ext  = {1'b0, acc} + {1'b0, term};
        ovf_hit  = sum_ext[SUM_W];
        acc_next = ovf_hit ? {SUM_W{1'b1}} : sum_ext[SUM_W-1:0];
    end

    assign sad_ovf = ovf_q;
`else
    // plain modulo-2^SUM_W accumulation
    always_comb begin
        acc_next = acc + term;
    end

    assign sad_ovf = 1'b0;
`endif

    // index and accumulator: rst wins over en; index stops at N
    always_ff @(posedge clk or posedge Mrst) begin
        if (Mrst) begin
            idx <= '0;
            acc <= '0;
`ifdef SAD_SAT_EN
            ovf_q <= 1'b0;
`endif
        end else if (rst) begin
            idx <= '0;
            acc <= '0;
`ifdef SAD_SAT_EN
            ovf_q <= 1'b0;
`endif
        end else if (en && !comp) begin
            idx <= idx + (ADDR_W+1)'(1);
            acc <= acc_next;
`ifdef SAD_SAT_EN
            ovf_q <= ovf_q | ovf_hit;
`endif
        end
    end

    // result register: captures pre-edge acc, unaffected by rst
    always_ff @(posedge clk or posedge Mrst) begin
        if (Mrst) begin
            sad       <= '0;
            sad_valid <= 1'b0;
        end else begin
            sad_valid <= en_reg;
            if (en_reg) begin
                sad <= acc;
            end
        end
    end

endmodule

// File: doc/sad_datapath.md
# sad_datapath

Arithmetic datapath of the SAD (sum of absolute differences) engine, driven by the SAD control FSM. Steps an element index across two equal-length pixel blocks, accumulates |A−B| per element, raises `comp` to the FSM when the block is exhausted and registers the final sum on command. Pixel memories sit outside, addressed by `addr` with combinational (asynchronous) read.

## Interface
- `PIX_W`, 8, pixel width in bits (unsigned)
- `N`, 256, elements per block; N ≥ 1 and N ≤ 2^ADDR_W
- `ADDR_W`, 8, address width
- `SUM_W`, 16, accumulator/result width; must be ≥ PIX_W
- `clk`  in  1  clock, rising edge
- `Mrst`  in  1  asynchronous, active-high master reset
- `rst`  in  1  synchronous clear of index and accumulator (from FSM)
- `en`  in  1  accumulate current element and advance index (from FSM)
- `en_reg`  in  1  load result register (from FSM)
- `a_pix`  in  PIX_W  element A at `addr`
- `b_pix`  in  PIX_W  element B at `addr`
- `addr`  out  ADDR_W  current element address
- `comp`  out  1  high when index == N
- `sad`  out  SUM_W  registered SAD result
- `sad_valid`  out  1  one-cycle pulse, result just loaded
- `sad_ovf`  out  1  sticky overflow flag (see Configuration)

## Operation
- State: index register `idx` (ADDR_W+1 bits), accumulator `acc` (SUM_W), result `sad`, `sad_valid`, `sad_ovf`.
- `Mrst` asserted: `idx`=0, `acc`=0, `sad`=0, `sad_valid`=0, `sad_ovf`=0 immediately, independent of `clk`; thus `addr`=0, `comp`=0 (N ≥ 1).
- Per rising edge, priority `rst` > `en`:
  - `rst`: `idx`←0, `acc`←0, `sad_ovf`←0. `en` ignored this cycle.
  - `en` and `comp`=0: `acc`←`acc`+|`a_pix`−`b_pix`|, `idx`←`idx`+1.
  - `en` and `comp`=1: no change (index never wraps, no extra term added).
- |A−B| computed on PIX_W+1-bit difference, zero-extended to SUM_W before add.
- `addr` = `idx[ADDR_W-1:0]`; `comp` = (`idx` == N); both combinational from `idx`.
- `en_reg` independent of `rst`/`en`: `sad`←`acc` (value before any same-edge update); `sad_valid`←1 on that edge, ←0 on every edge without `en_reg`.
- `sad` holds until next `en_reg` or `Mrst`; `rst` does not clear it.

## Timing
- `addr` valid same cycle as `idx`; `a_pix`/`b_pix` must be valid before the `en` edge (single-cycle read path).
- After `rst` edge, `comp` rises after exactly N `en` edges; idle cycles (`en`=0) pause without loss.
- `en_reg` at edge k: `sad` and `sad_valid`=1 visible from k until edge k+1.
- `en_reg` with `en` same edge: `sad` gets pre-accumulation value.
- `Mrst` mid-block: all state cleared asynchronously; deassertion takes effect at next edge with `rst`/`en` as sampled.

## Configuration
- `SAD_SAT_EN` defined: on an add whose true sum exceeds 2^SUM_W−1, `acc` clamps to 2^SUM_W−1 and `sad_ovf`←1 (sticky until `rst`/`Mrst`); `acc` stays clamped on further adds.
- Undefined: `acc` wraps modulo 2^SUM_W; `sad_ovf` tied 0. Default widths cannot overflow (255·256 = 65280).

## Test plan
- N=4, ADDR_W=2, SUM_W=10; A={10,200,0,50}, B={12,100,0,60}; `rst`, 4×`en`, `en_reg` -> `comp`=1 after 4th `en`, `sad`=112, `sad_valid` one cycle, `addr` 0,1,2,3,0.
- Same block, `en` gapped with idle cycles and 2 extra `en` after `comp` -> `sad`=112, `idx` stays 4.
- `rst` and `en` same edge with `acc`=37 -> `acc`=0, `idx`=0, no add.
- `Mrst` pulsed between clock edges mid-block after `en_reg` loaded 112 -> `sad`=0, `comp`=0, `addr`=0 before next edge.
- `SAD_SAT_EN`, SUM_W=8, N=4, A={255,255,0,0}, B={0,0,0,0} -> `sad`=255, `sad_ovf`=1; without macro -> `sad`=254, `sad_ovf`=0.
- `en_reg` coincident with last `en` (`acc`=102, term 10) -> `sad`=102; second `en_reg` next cycle -> `sad`=112.
